// File: rtl/merge_pkg.sv
// Shared helpers for the pipelined odd-even merger: sizing functions, pair
// selection for each comparator level, and an element-slice macro.
`ifndef MERGE_PKG_SV
`define MERGE_PKG_SV

// Element k of a flat packed list with w bits per element.
`define MERGE_ELEM(vec, k, w) vec[(k)*(w) +: (w)]

package merge_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // Compare distance of comparator level s for two lists of n elements.
  function automatic int stage_distance(input int s, input int n);
    return n >> s;
  endfunction

  // True when index i is the lower element of a compare pair at level s.
  function automatic bit pair_lo(input int s, input int i, input int n);
    int d;
    d = stage_distance(s, n);
    if (s == 0) return i < n;
    return (((i / d) % 2) == 1) && (i + d < 2 * n);
  endfunction

endpackage

`endif

// File: rtl/merge_pipe_nto2n_cmp_swap.sv
// Combinational compare-exchange cell: l=min, h=max, ties keep a on l.
// With MERGE_PIPE_TAG_EN the tags follow their keys through the swap.
module cmp_swap #(
  parameter int WIDTH = 3
`ifdef MERGE_PIPE_TAG_EN
  , parameter int TAGW = 1
`endif
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MERGE_PIPE_TAG_EN
  input  logic [TAGW-1:0]  a_tag,
  input  logic [TAGW-1:0]  b_tag,
  output logic [TAGW-1:0]  l_tag,
  output logic [TAGW-1:0]  h_tag,
`endif
  output logic [WIDTH-1:0] l,
  output logic [WIDTH-1:0] h
);

  logic swap;

  // Strict compare so equal keys never move.
  assign swap = b < a;
  assign l    = swap ? b : a;
  assign h    = swap ? a : b;

`ifdef MERGE_PIPE_TAG_EN
  assign l_tag = swap ? b_tag : a_tag;
  assign h_tag = swap ? a_tag : b_tag;
`endif

endmodule

// File: rtl/merge_pipe_nto2n.sv
// Batcher odd-even merge of two sorted N-lists, one comparator level per stage,
// latency STAGES, whole pipeline stalls when the output is held. Tags: MERGE_PIPE_TAG_EN.
module merge_pipe_nto2n
  import merge_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int N     = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [2*N*WIDTH-1:0]                 in_data,
`ifdef MERGE_PIPE_TAG_EN
  input  logic [2*N*clog2(2*N)-1:0]            in_tag,
  output logic [2*N*clog2(2*N)-1:0]            out_tag,
`endif
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [2*N*WIDTH-1:0]                 out_data,
  output logic [clog2(clog2(2*N)+1)-1:0]       in_flight
);

  localparam int STAGES = clog2(2 * N);
  localparam int DW     = 2 * N * WIDTH;
  localparam int IFW    = clog2(STAGES + 1);

  logic [DW-1:0]     lvl_in  [STAGES];
  logic [DW-1:0]     lvl_out [STAGES];
  logic [DW-1:0]     stg_dat [STAGES];
  logic [STAGES-1:0] stg_vld;
  logic              advance;
  logic              xfer_in;
  logic              xfer_out;

`ifdef MERGE_PIPE_TAG_EN
  localparam int TAGW = clog2(2 * N);
  localparam int TDW  = 2 * N * TAGW;
  logic [TDW-1:0] tag_in  [STAGES];
  logic [TDW-1:0] tag_out [STAGES];
  logic [TDW-1:0] stg_tag [STAGES];
`endif

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = out_valid && out_ready;
  assign out_valid = stg_vld[STAGES-1];
  assign out_data  = stg_dat[STAGES-1];
`ifdef MERGE_PIPE_TAG_EN
  assign out_tag   = stg_tag[STAGES-1];
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_lvl
    localparam int D = stage_distance(s, N);

    if (s == 0) begin : g_src_in
      assign lvl_in[s] = in_data;
`ifdef MERGE_PIPE_TAG_EN
      assign tag_in[s] = in_tag;
`endif
    end else begin : g_src_stg
      assign lvl_in[s] = stg_dat[s-1];
`ifdef MERGE_PIPE_TAG_EN
      assign tag_in[s] = stg_tag[s-1];
`endif
    end

    // Each pair is owned by its lower index; upper indices are driven there.
    for (genvar i = 0; i < 2 * N; i++) begin : g_el
      if (pair_lo(s, i, N)) begin : g_cmp
        cmp_swap #(
          .WIDTH (WIDTH)
`ifdef MERGE_PIPE_TAG_EN
          , .TAGW (TAGW)
`endif
        ) u_cmp (
          .a     (`MERGE_ELEM(lvl_in[s], i, WIDTH)),
          .b     (`MERGE_ELEM(lvl_in[s], i + D, WIDTH)),
`ifdef MERGE_PIPE_TAG_EN
          .a_tag (`MERGE_ELEM(tag_in[s], i, TAGW)),
          .b_tag (`MERGE_ELEM(tag_in[s], i + D, TAGW)),
          .l_tag (`MERGE_ELEM(tag_out[s], i, TAGW)),
          .h_tag (`MERGE_ELEM(tag_out[s], i + D, TAGW)),
`endif
          .l     (`MERGE_ELEM(lvl_out[s], i, WIDTH)),
          .h     (`MERGE_ELEM(lvl_out[s], i + D, WIDTH))
        );
      end else if (!(i >= D && pair_lo(s, i - D, N))) begin : g_pass
        assign `MERGE_ELEM(lvl_out[s], i, WIDTH) = `MERGE_ELEM(lvl_in[s], i, WIDTH);
`ifdef MERGE_PIPE_TAG_EN
        assign `MERGE_ELEM(tag_out[s], i, TAGW) = `MERGE_ELEM(tag_in[s], i, TAGW);
`endif
      end
    end
  end

  // Bubbles travel with the data; nothing collapses while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld <= '0;
      for (int s = 0; s < STAGES; s++) begin
        stg_dat[s] <= '0;
`ifdef MERGE_PIPE_TAG_EN
        stg_tag[s] <= '0;
`endif
      end
    end else if (advance) begin
      stg_vld[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) stg_vld[s] <= stg_vld[s-1];
      for (int s = 0; s < STAGES; s++) begin
        stg_dat[s] <= lvl_out[s];
`ifdef MERGE_PIPE_TAG_EN
        stg_tag[s] <= tag_out[s];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else begin
      case ({xfer_in, xfer_out})
        2'b10:   in_flight <= in_flight + IFW'(1);
        2'b01:   in_flight <= in_flight - IFW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule
